// File: rtl/data_mem_unit.sv
// ---------------------------------------------------------------------------
// data_mem_unit
//   Word-addressed data memory with a registered read port and a fixed
//   multi-cycle read latency. Sits after the single-cycle datapath: takes the
//   ALU result as a byte address plus store data, and returns registered load
//   data to the write-back mux. Stall holds the core's PC/Instr while a read
//   is in flight. Writes complete in one cycle without stalling.
//
// Parameters
//   DEPTH     number of 32-bit words (power of two, >= 4)
//   READ_LAT  stall cycles per read (1..15)
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high reset
//   MemRead    in   1   read request (held by the core while Stall=1)
//   MemWrite   in   1   write request (wins over MemRead when both are set)
//   Addr       in   32  byte address
//   WriteData  in   32  store data
//   ByteEn     in   4   per-lane write enable (only with DMEM_BYTE_EN)
//   ReadData   out  32  registered load data, held until the next read
//   Stall      out  1   core must hold PC/Instr this cycle
//   AddrError  out  1   sticky misaligned / out-of-range access flag
//
// Build option
//   DMEM_BYTE_EN  when defined, adds ByteEn and writes only enabled byte
//                 lanes (lane0 = bits 7:0); otherwise writes whole words.
// ---------------------------------------------------------------------------
module data_mem_unit #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned READ_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]  ByteEn,
`endif
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AddrError
);

  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);
  localparam int unsigned CNT_INIT_I = (READ_LAT > 1) ? READ_LAT - 2 : 0;
  localparam logic [3:0]  CNT_INIT   = 4'(CNT_INIT_I);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             addr_error_q, addr_error_d;

  // Storage is deliberately not reset.
  logic [31:0]      mem [DEPTH];

  logic             addr_ok;
  logic [IDX_W-1:0] addr_idx;
  logic             wr_en;
  logic [31:0]      wr_word;

  assign addr_ok  = (Addr[1:0] == 2'b00) && (Addr < ADDR_LIMIT);
  assign addr_idx = Addr[IDX_W+1:2];

  // Merged write word: with byte enables the untouched lanes keep the
  // current contents, so a single full-word write port suffices.
  always_comb begin
`ifdef DMEM_BYTE_EN
    wr_word = mem[addr_idx];
    for (int unsigned lane = 0; lane < 4; lane++) begin
      if (ByteEn[lane]) begin
        wr_word[lane*8 +: 8] = WriteData[lane*8 +: 8];
      end
    end
`else
    wr_word = WriteData;
`endif
  end

  // Next-state / output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    read_data_d  = read_data_q;
    addr_error_d = addr_error_q;
    wr_en        = 1'b0;
    Stall        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (MemRead || MemWrite) begin
          if (!addr_ok) begin
            addr_error_d = 1'b1;
          end else if (MemWrite) begin
            wr_en = 1'b1;
          end else begin
            Stall = 1'b1;
            idx_d = addr_idx;
            if (READ_LAT == 1) begin
              // Single-cycle latency: the latched index is only being
              // captured at this edge, so load from the live address.
              state_d     = ST_DONE;
              read_data_d = mem[addr_idx];
            end else begin
              state_d = ST_WAIT;
              cnt_d   = CNT_INIT;
            end
          end
        end
      end

      ST_WAIT: begin
        Stall = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d     = ST_DONE;
          read_data_d = mem[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_DONE: begin
        // A MemRead still asserted here belongs to the finished read.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (reset) begin
      Stall = 1'b0;
      wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      read_data_q  <= '0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      read_data_q  <= read_data_d;
      addr_error_q <= addr_error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr_idx] <= wr_word;
    end
  end

  assign ReadData  = read_data_q;
  assign AddrError = addr_error_q;

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned RL    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
`ifdef DMEM_BYTE_EN
  logic [3:0]  ByteEn;
`endif
  logic [31:0] ReadData;
  logic        Stall;
  logic        AddrError;

  int unsigned vecs = 0;
  int unsigned miss = 0;
  logic [31:0] exp_q [$];

  data_mem_unit #(
    .DEPTH    (DEPTH),
    .READ_LAT (RL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
`ifdef DMEM_BYTE_EN
    .ByteEn    (ByteEn),
`endif
    .ReadData  (ReadData),
    .Stall     (Stall),
    .AddrError (AddrError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    Addr      = a;
    WriteData = d;
    #3;
    chk("wr_nostall", {31'd0, Stall}, 32'd0);
    cyc();
    MemWrite = 1'b0;
  endtask

  // Issue a read, count stall cycles until the DUT signals completion,
  // then pop the scoreboard and compare.
  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    int unsigned n = 0;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    Addr     = a;
    exp_q.push_back(exp);
    #3;
    while (Stall === 1'b1 && n < 20) begin
      n++;
      cyc();
      #3;
    end
    chk("rd_stall_cycles", 32'(n), 32'(RL));
    chk("rd_data", ReadData, exp_q.pop_front());
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Addr      = '0;
    WriteData = '0;
`ifdef DMEM_BYTE_EN
    ByteEn    = 4'hF;
`endif

    // 1. reset
    cyc();
    cyc();
    #3;
    chk("rst_readdata", ReadData, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_addrerr", {31'd0, AddrError}, 32'd0);
    reset = 1'b0;
    cyc();

    // 2. write then read with latency
    wr(32'h10, 32'hDEADBEEF);
    rd(32'h10, 32'hDEADBEEF);
    MemRead = 1'b0;
    #3;
    chk("post_read_stall", {31'd0, Stall}, 32'd0);
    chk("post_read_hold", ReadData, 32'hDEADBEEF);
    cyc();

    // 3. back-to-back reads
    wr(32'h14, 32'h12345678);
    rd(32'h10, 32'hDEADBEEF);
    rd(32'h14, 32'h12345678);
    MemRead = 1'b0;
    #3;
    chk("b2b_idle_stall", {31'd0, Stall}, 32'd0);
    chk("b2b_hold", ReadData, 32'h12345678);
    cyc();

    // 4. invalid accesses
    wr(32'h0, 32'h11111111);
    MemWrite  = 1'b1;
    Addr      = 32'h13;
    WriteData = 32'hBAD0BAD0;
    #3;
    chk("mis_nostall", {31'd0, Stall}, 32'd0);
    chk("mis_err_before", {31'd0, AddrError}, 32'd0);
    cyc();
    MemWrite = 1'b0;
    #3;
    chk("mis_err_after", {31'd0, AddrError}, 32'd1);
    cyc();
    MemRead = 1'b1;
    Addr    = 32'(DEPTH * 4);
    #3;
    chk("oor_rd_nostall", {31'd0, Stall}, 32'd0);
    cyc();
    MemRead = 1'b0;
    #3;
    chk("oor_rd_nostall2", {31'd0, Stall}, 32'd0);
    cyc();
    wr(32'(DEPTH * 4), 32'hBADBAD00);
    rd(32'h10, 32'hDEADBEEF);
    rd(32'h0, 32'h11111111);
    MemRead = 1'b0;
    #3;
    chk("err_sticky", {31'd0, AddrError}, 32'd1);
    cyc();

    // 5. read+write together acts as a write only
    MemRead   = 1'b1;
    MemWrite  = 1'b1;
    Addr      = 32'h20;
    WriteData = 32'hA5A5A5A5;
    #3;
    chk("rw_nostall", {31'd0, Stall}, 32'd0);
    cyc();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    #3;
    chk("rw_no_read", {31'd0, Stall}, 32'd0);
    cyc();
    rd(32'h20, 32'hA5A5A5A5);
    MemRead = 1'b0;
    cyc();

    // 6. reset while a read is waiting
    MemRead = 1'b1;
    Addr    = 32'h10;
    #3;
    chk("mid_req_stall", {31'd0, Stall}, 32'd1);
    cyc();
    #3;
    chk("mid_wait_stall", {31'd0, Stall}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_stall", {31'd0, Stall}, 32'd0);
    cyc();
    reset   = 1'b0;
    MemRead = 1'b0;
    #3;
    chk("mid_rst_stall2", {31'd0, Stall}, 32'd0);
    chk("mid_rst_data", ReadData, 32'd0);
    chk("mid_rst_err", {31'd0, AddrError}, 32'd0);
    cyc();
    rd(32'h10, 32'hDEADBEEF);
    MemRead = 1'b0;
    cyc();

`ifdef DMEM_BYTE_EN
    ByteEn = 4'b0001;
    wr(32'h10, 32'h000000FF);
    ByteEn = 4'b0000;
    wr(32'h0, 32'hFFFFFFFF);
    ByteEn = 4'hF;
    rd(32'h10, 32'hDEADBEFF);
    rd(32'h0, 32'h11111111);
    MemRead = 1'b0;
    cyc();
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
